// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: read strobe, data, status and error pulses.
// Optional UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (
    input  rd_en,
    output rx_data, rx_valid, frame_err, overrun_err, busy, parity_err
  );
  modport slave (
    output rd_en,
    input  rx_data, rx_valid, frame_err, overrun_err, busy, parity_err
  );
`else
  modport master (
    input  rd_en,
    output rx_data, rx_valid, frame_err, overrun_err, busy
  );
  modport slave (
    output rd_en,
    input  rx_data, rx_valid, frame_err, overrun_err, busy
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch reject, LSB-first data, stop check, overrun/break.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     baud_clk,
  input  logic     rx,
  uart_rx_if.master bus
);

  localparam int unsigned TICK_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W     = $clog2(DATA_BITS + 1);
  localparam int unsigned TICK_LAST = OVERSAMPLE - 1;
  localparam int unsigned TICK_HALF = OVERSAMPLE / 2 - 1;
  localparam int unsigned BIT_LAST  = DATA_BITS - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 busy_q, busy_d;
  logic                 rx_meta, rx_sync;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
`endif

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif

    // A read clears valid; a byte landing on the same clock re-sets it below
    if (bus.rd_en) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (baud_clk) begin
          if (tick_q == TICK_W'(TICK_HALF)) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_sync ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (baud_clk) begin
          if (tick_q == TICK_W'(TICK_LAST)) begin
            tick_d  = '0;
            shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_clk) begin
          if (tick_q == TICK_W'(TICK_LAST)) begin
            tick_d  = '0;
            par_d   = rx_sync;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
`endif

      STOP: begin
        if (baud_clk) begin
          if (tick_q == TICK_W'(TICK_LAST)) begin
            tick_d = '0;
            if (rx_sync) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              ov_d    = valid_q & ~bus.rd_en;
`ifdef UART_RX_PARITY_EN
              pe_d    = ^{shift_q, par_q};
`endif
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = BREAK;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      // Line held low past the stop bit: wait for it to return high
      BREAK: begin
        if (rx_sync) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_err   = fe_q;
  assign bus.overrun_err = ov_q;
  assign bus.busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = pe_q;
`endif

endmodule
